// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode legality check and the
// frame sequencer state encoding.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_frame_ctrl_if.sv
// Byte-stream link between the UART RX/TX pair (master) and the frame
// sequencer (slave).
interface alu_frame_ctrl_if #(parameter int N = 8);
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         tx_busy;
  logic [N-1:0] tx_data;
  logic         tx_start;

  modport master (output rx_data, rx_valid, tx_busy, input tx_data, tx_start);
  modport slave  (input rx_data, rx_valid, tx_busy, output tx_data, tx_start);
endinterface

// File: rtl/alu_frame_ctrl_timer.sv
// Inter-byte watchdog: counts enabled cycles, fires when the count would
// reach TIMEOUT_CYC-1. Clear has priority over count.
module frame_timer #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  assign expired = en && (r_cnt == CW'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (clr)    r_cnt <= '0;
    else if (en)     r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/alu_frame_ctrl.sv
// Collects A/B/opcode bytes, drives the external ALU from registers and
// hands the result to the transmitter with a start/busy handshake.
module alu_frame_ctrl
  import alu_pkg::*;
#(
  parameter int N           = 8,
  parameter int OPW         = OP_W,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_frame_ctrl_if.slave  bus,
  output logic [N-1:0]     A,
  output logic [N-1:0]     B,
  output logic [OPW-1:0]   Op,
  input  logic [N-1:0]     Result,
  output logic             busy,
  output logic             err_op,
  output logic             err_ovr,
  output logic             err_tmo
);
  state_t         r_state;
  logic [N-1:0]   r_a, r_b, r_tx_data;
  logic [OPW-1:0] r_op;
  logic           r_err_op, r_err_ovr, r_err_tmo;
  logic           w_op_legal, w_tmr_clr, w_tmr_en, w_tmo;

  assign w_op_legal = (bus.rx_data[N-1:OPW] == '0) && is_legal_op(bus.rx_data[OPW-1:0]);

  // Counting only while waiting mid-frame with no byte, so a byte arriving
  // on the expiry cycle always wins.
  assign w_tmr_en  = ((r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP)) && !bus.rx_valid;
  assign w_tmr_clr = bus.rx_valid || !((r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP));

  frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_tmr_clr),
    .en      (w_tmr_en),
    .expired (w_tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_WAIT_A;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_tx_data <= '0;
      r_err_op  <= 1'b0;
      r_err_ovr <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_err_op  <= 1'b0;
      r_err_ovr <= 1'b0;
      r_err_tmo <= 1'b0;
      case (r_state)
        ST_WAIT_A: if (bus.rx_valid) begin
          r_a     <= bus.rx_data;
          r_state <= ST_WAIT_B;
        end
        ST_WAIT_B: if (bus.rx_valid) begin
          r_b     <= bus.rx_data;
          r_state <= ST_WAIT_OP;
        end else if (w_tmo) begin
          r_err_tmo <= 1'b1;
          r_state   <= ST_WAIT_A;
        end
        ST_WAIT_OP: if (bus.rx_valid) begin
          if (w_op_legal) begin
            r_op    <= bus.rx_data[OPW-1:0];
            r_state <= ST_EXEC;
          end else begin
            r_err_op <= 1'b1;
            r_state  <= ST_WAIT_A;
          end
        end else if (w_tmo) begin
          r_err_tmo <= 1'b1;
          r_state   <= ST_WAIT_A;
        end
        ST_EXEC: begin
          r_tx_data <= Result;
          r_err_ovr <= bus.rx_valid;
          r_state   <= ST_SEND;
        end
        ST_SEND: begin
          r_err_ovr <= bus.rx_valid;
          if (!bus.tx_busy) r_state <= ST_WAIT_A;
        end
        default: r_state <= ST_WAIT_A;
      endcase
    end
  end

  assign A            = r_a;
  assign B            = r_b;
  assign Op           = r_op;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = (r_state == ST_SEND) && !bus.tx_busy;
  assign busy         = (r_state != ST_WAIT_A);
  assign err_op       = r_err_op;
  assign err_ovr      = r_err_ovr;
  assign err_tmo      = r_err_tmo;
endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl with a behavioural ALU beside it.
module tb_alu_frame_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] A, B, Result;
  logic [5:0] Op;
  logic       busy, err_op, err_ovr, err_tmo;
  int         n_chk = 0, n_pass = 0, n_start = 0;

  alu_frame_ctrl_if #(.N(8)) bus ();

  alu_frame_ctrl #(.N(8), .OPW(6), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .A(A), .B(B), .Op(Op), .Result(Result),
    .busy(busy), .err_op(err_op), .err_ovr(err_ovr), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  always_comb begin
    Result = 8'h00;
    case (Op)
      OP_ADD: Result = A + B;
      OP_SUB: Result = A - B;
      OP_AND: Result = A & B;
      OP_OR:  Result = A | B;
      OP_XOR: Result = A ^ B;
      OP_NOR: Result = ~(A | B);
      OP_SRL: Result = A >> B;
      OP_SRA: Result = 8'($signed(A) >>> B);
      default: Result = 8'h00;
    endcase
  end

  always @(posedge clk) if (bus.tx_start) n_start <= n_start + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge after the op edge (DUT in EXEC or WAIT_A).
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  // Legal frame with idle transmitter: check result and one start pulse.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
    int s0;
    s0 = n_start;
    send_frame(a, b, op);
    chk({tag, "_exec_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_start"}, bus.tx_start, 1);
    chk({tag, "_txdata"}, bus.tx_data, exp);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_nstart"}, n_start - s0, 1);
  endtask

  initial begin
    int s0, tmo_k;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    #12;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_Op", Op, 0);
    chk("rst_txdata", bus.tx_data, 0);
    chk("rst_flags", {busy, bus.tx_start, err_op, err_ovr, err_tmo}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("add", 8'd10, 8'd5, 8'h20, 8'd15);
    chk("add_A", A, 10);
    chk("add_B", B, 5);
    chk("add_Op", Op, 6'b100000);
    run_frame("nor", 8'hF0, 8'hAA, 8'h27, 8'h05);
    run_frame("sra", 8'hF0, 8'h02, 8'h03, 8'hFC);

    // Illegal opcodes: dropped, Op keeps SRA.
    s0 = n_start;
    send_frame(8'd10, 8'd5, 8'h2A);
    chk("ill_err_op", err_op, 1);
    chk("ill_busy", busy, 0);
    chk("ill_Op", Op, 6'b000011);
    send_frame(8'd10, 8'd5, 8'h60);
    chk("upper_err_op", err_op, 1);
    chk("upper_busy", busy, 0);
    @(negedge clk);
    chk("ill_err_clear", err_op, 0);
    chk("ill_nstart", n_start - s0, 0);

    // Transmitter busy across SEND entry, extra byte during the wait.
    bus.tx_busy = 1'b1;
    s0 = n_start;
    send_frame(8'h33, 8'h0F, 8'h26);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) begin bus.rx_data = 8'h99; bus.rx_valid = 1'b1; end
      if (i == 11) begin
        bus.rx_valid = 1'b0;
        chk("ovr_err", err_ovr, 1);
        chk("ovr_txdata", bus.tx_data, 8'h3C);
        chk("ovr_busy", busy, 1);
      end
    end
    chk("wait_nostart", n_start - s0, 0);
    chk("wait_A", A, 8'h33);
    bus.tx_busy = 1'b0;
    #1;
    chk("release_start", bus.tx_start, 1);
    @(negedge clk);
    chk("release_nstart", n_start - s0, 1);
    chk("release_idle", busy, 0);
    chk("release_txdata", bus.tx_data, 8'h3C);

    // Timeout after a lone A byte.
    send_byte(8'h55);
    tmo_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err_tmo && tmo_k < 0) tmo_k = k;
    end
    chk("tmo_cycle", tmo_k, 15);
    chk("tmo_idle", busy, 0);
    chk("tmo_A_kept", A, 8'h55);
    run_frame("after_tmo", 8'h0C, 8'h0A, 8'h25, 8'h0E);

    // Reset in WAIT_OP.
    s0 = n_start;
    send_byte(8'd7);
    send_byte(8'd8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_AB", {A, B}, 0);
    chk("mid_rst_txdata", bus.tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("sub", 8'd3, 8'd4, 8'h22, 8'hFF);
    chk("rst_total_starts", n_start - s0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d done", n_pass, n_chk);
    $fatal(1);
  end
endmodule
